set_ctrl: RTL

//  Top-level sequencer for the SET engine. Accepts a job request and loads the input buffer.

---
 rtl/set_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/set_ctrl.sv
// set_ctrl: top-level sequencer for the SET engine.
// Accepts a job, loads the input buffer, walks all GRID_N x GRID_N grid
// points through the membership datapath, counts the in-set responses,
// reports the count for one cycle and clears the input buffer.
//
// Handshake: pt_vld_o marks x_o/y_o as a valid point in the cycle it is high;
// there is no back-pressure, the datapath must accept one point per cycle.
// hit_vld_i marks hit_i valid; responses arrive in point order, one per point.
module set_ctrl #(
  parameter int GRID_N  = 8,
  parameter int COORD_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  output logic               buffer_en_o,
  output logic               clear_o,
  output logic [1:0]         mode_o,
  output logic               pt_vld_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  input  logic               hit_vld_i,
  input  logic               hit_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   candidate_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [COORD_W-1:0] GRID_C   = COORD_W'(GRID_N);
  localparam logic [COORD_W-1:0] COORD_1  = COORD_W'(1);
  localparam logic [CNT_W-1:0]   NPTS     = CNT_W'(GRID_N * GRID_N);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   resp_q, resp_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   cand_q, cand_d;

  // Response counting window: the datapath may still answer after the scan.
  logic counting;
  assign counting = (state_q == S_SCAN) || (state_q == S_WAIT);

  // Next-state logic: sequencing, point walk and response/hit counting.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    resp_d  = resp_q;
    hit_d   = hit_q;
    cand_d  = cand_q;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_SCAN;
          mode_d  = mode_i;
          x_d     = COORD_1;
          y_d     = COORD_1;
          resp_d  = '0;
          hit_d   = '0;
          cand_d  = '0;
        end
      end
      S_SCAN: begin
        if (x_q == GRID_C) begin
          x_d = COORD_1;
          if (y_q == GRID_C) begin
            y_d     = COORD_1;
            state_d = S_WAIT;
          end else begin
            y_d = y_q + COORD_1;
          end
        end else begin
          x_d = x_q + COORD_1;
        end
      end
      S_WAIT: begin
        // Registered count: the last response must have landed already,
        // so hit_q is final when it is copied.
        if (resp_q == NPTS) begin
          state_d = S_DONE;
          cand_d  = hit_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (counting && hit_vld_i) begin
      resp_d = resp_q + CNT_W'(1);
      if (hit_i && (hit_q != CNT_MAX)) begin
        hit_d = hit_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      x_q     <= COORD_1;
      y_q     <= COORD_1;
      mode_q  <= 2'd0;
      resp_q  <= '0;
      hit_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      resp_q  <= resp_d;
      hit_q   <= hit_d;
      cand_q  <= cand_d;
    end
  end

  // buffer_en_o is combinational so the buffer captures inputs in the en_i cycle;
  // it is only ever high in IDLE, so it can never overlap clear_o=0 (DONE).
  assign buffer_en_o = (state_q == S_IDLE) && en_i;
  assign clear_o     = (state_q != S_DONE);
  assign valid_o     = (state_q == S_DONE);
  assign pt_vld_o    = (state_q == S_SCAN);
  assign busy_o      = (state_q != S_IDLE);
  assign mode_o      = mode_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign candidate_o = cand_q;

endmodule
